// File: rtl/cache_axi_lite_master_pkg.sv
// Shared types and constants for the cache-to-AXI4-Lite downstream stage.
//   rd_state_e : read-miss fill FSM states
//   wr_state_e : write-through FSM states
//   RESP_OKAY  : AXI OKAY response code
package cache_axi_pkg;

   typedef enum logic [1:0] {
      R_IDLE = 2'd0,
      R_AR   = 2'd1,
      R_DATA = 2'd2,
      R_HOLD = 2'd3
   } rd_state_e;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_ADDR = 2'd1,
      W_RESP = 2'd2,
      W_DONE = 2'd3
   } wr_state_e;

   localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage

// File: rtl/cache_axi_lite_master_sync_fifo.sv
// Single-clock FIFO used to queue outstanding read-miss addresses.
//   i_clk          : clock
//   i_rstn         : synchronous active-low reset (empties the FIFO)
//   i_push/i_data  : write one entry; accepted when not full, or when full
//                    and a pop happens in the same cycle
//   i_pop          : remove head entry (ignored when empty)
//   o_data         : head entry, valid while o_empty=0
//   o_full/o_empty : occupancy flags
module sync_fifo #(
   parameter int FIFO_WIDTH = 32,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                  i_clk,
   input  logic                  i_rstn,
   input  logic                  i_push,
   input  logic [FIFO_WIDTH-1:0] i_data,
   input  logic                  i_pop,
   output logic [FIFO_WIDTH-1:0] o_data,
   output logic                  o_full,
   output logic                  o_empty
);

   localparam int          AW      = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

   logic [FIFO_WIDTH-1:0] r_mem [FIFO_DEPTH];
   logic [AW:0]           r_wptr;
   logic [AW:0]           r_rptr;
   logic                  w_full;
   logic                  w_empty;
   logic                  w_do_push;
   logic                  w_do_pop;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign w_empty   = (r_wptr == r_rptr);
   assign w_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
   assign w_do_pop  = i_pop & ~w_empty;
   // At full, a same-cycle pop frees the head slot, which the push reuses.
   assign w_do_push = i_push & (~w_full | w_do_pop);

   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_do_push) r_wptr <= r_wptr + PTR_ONE;
         if (w_do_pop)  r_rptr <= r_rptr + PTR_ONE;
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_data;
   end

   assign o_data  = r_mem[r_rptr[AW-1:0]];
   assign o_full  = w_full;
   assign o_empty = w_empty;

endmodule

// File: rtl/cache_axi_lite_master.sv
// Downstream stage of the direct-mapped data cache. Turns the cache's read-miss
// pulses and write-through level requests into AXI4-Lite master traffic, with a
// single AXI transaction in flight at a time. Read-miss addresses are queued in a
// FIFO so back-to-back miss pulses are not lost.
//   Cache read side : rd_rq/rd_addr in; rd_data/rd_valid/rd_err out with 4-phase
//                     rd_valid_ack; rd_ovf sticky overflow flag
//   Cache write side: wr_rq/wr_addr/wr_data in, wr_rq_ack capture pulse;
//                     wr_done/wr_err out with 4-phase wr_done_ack
//   AXI4-Lite master: AR/R/AW/W/B channels, PROT tied to 3'b000
//   Debug           : o_dbg_rd_state / o_dbg_wr_state expose both FSMs
//
// Handshake rule on every AXI channel: a transfer happens on a rising edge where
// valid and ready are both 1. This block never drops a valid before its ready and
// keeps address/data stable while valid is high; ready outputs are pure
// acceptance and may be raised without waiting for valid.
module cache_axi_lite_master
   import cache_axi_pkg::*;
#(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int RD_DEPTH = 8
) (
   input  logic                axi_clk,
   input  logic                i_rst,
   input  logic                rd_rq,
   input  logic [ADDR_W-1:0]   rd_addr,
   output logic [DATA_W-1:0]   rd_data,
   output logic                rd_valid,
   input  logic                rd_valid_ack,
   output logic                rd_err,
   output logic                rd_ovf,
   input  logic                wr_rq,
   output logic                wr_rq_ack,
   input  logic [ADDR_W-1:0]   wr_addr,
   input  logic [DATA_W-1:0]   wr_data,
   output logic                wr_done,
   input  logic                wr_done_ack,
   output logic                wr_err,
   output logic [ADDR_W-1:0]   m_araddr,
   output logic [2:0]          m_arprot,
   output logic                m_arvalid,
   input  logic                m_arready,
   input  logic [DATA_W-1:0]   m_rdata,
   input  logic [1:0]          m_rresp,
   input  logic                m_rvalid,
   output logic                m_rready,
   output logic [ADDR_W-1:0]   m_awaddr,
   output logic [2:0]          m_awprot,
   output logic                m_awvalid,
   input  logic                m_awready,
   output logic [DATA_W-1:0]   m_wdata,
   output logic [DATA_W/8-1:0] m_wstrb,
   output logic                m_wvalid,
   input  logic                m_wready,
   input  logic [1:0]          m_bresp,
   input  logic                m_bvalid,
   output logic                m_bready,
   output rd_state_e           o_dbg_rd_state,
   output wr_state_e           o_dbg_wr_state
);

   localparam int                STRB_W     = DATA_W / 8;
   localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

   rd_state_e           r_rd_state, w_rd_state_nxt;
   wr_state_e           r_wr_state, w_wr_state_nxt;

   logic [ADDR_W-1:0]   r_araddr, w_araddr_nxt;
   logic                r_arvalid, w_arvalid_nxt;
   logic                r_rready, w_rready_nxt;
   logic [DATA_W-1:0]   r_rd_data, w_rd_data_nxt;
   logic                r_rd_valid, w_rd_valid_nxt;
   logic                r_rd_err, w_rd_err_nxt;
   logic                r_rd_ovf, w_rd_ovf_nxt;

   logic [ADDR_W-1:0]   r_awaddr, w_awaddr_nxt;
   logic [DATA_W-1:0]   r_wdata, w_wdata_nxt;
   logic [STRB_W-1:0]   r_wstrb, w_wstrb_nxt;
   logic                r_awvalid, w_awvalid_nxt;
   logic                r_wvalid, w_wvalid_nxt;
   logic                r_bready, w_bready_nxt;
   logic                r_wr_done, w_wr_done_nxt;
   logic                r_wr_err, w_wr_err_nxt;
   logic                r_wr_rq_ack, w_wr_rq_ack_nxt;

   logic [ADDR_W-1:0]   w_fifo_head;
   logic                w_fifo_full;
   logic                w_fifo_empty;
   logic                w_fifo_push;
   logic                w_rd_start;
   logic                w_wr_start;
   logic                w_fifo_rstn;

   // Reads launch only from a quiet write side. Writes launch only while no read
   // occupies the bus, and yield when a read is starting now or a miss pulse
   // arrives at an idle read FSM (that read starts next cycle, so read wins ties).
   assign w_rd_start = (r_rd_state == R_IDLE) & ~w_fifo_empty & (r_wr_state == W_IDLE);
   assign w_wr_start = (r_wr_state == W_IDLE) & wr_rq & ~w_rd_start
                     & ((r_rd_state == R_HOLD) | ((r_rd_state == R_IDLE) & ~rd_rq));

   assign w_fifo_push = rd_rq & (~w_fifo_full | w_rd_start);
   assign w_fifo_rstn = ~i_rst;

   sync_fifo #(
      .FIFO_WIDTH (ADDR_W),
      .FIFO_DEPTH (RD_DEPTH)
   ) u_rd_fifo (
      .i_clk   (axi_clk),
      .i_rstn  (w_fifo_rstn),
      .i_push  (w_fifo_push),
      .i_data  (rd_addr),
      .i_pop   (w_rd_start),
      .o_data  (w_fifo_head),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty)
   );

   always_comb begin
      w_rd_state_nxt = r_rd_state;
      w_araddr_nxt   = r_araddr;
      w_arvalid_nxt  = r_arvalid;
      w_rready_nxt   = r_rready;
      w_rd_data_nxt  = r_rd_data;
      w_rd_valid_nxt = r_rd_valid;
      w_rd_err_nxt   = r_rd_err;
      w_rd_ovf_nxt   = r_rd_ovf | (rd_rq & w_fifo_full & ~w_rd_start);
      case (r_rd_state)
         R_IDLE: if (w_rd_start) begin
            w_araddr_nxt   = w_fifo_head & ALIGN_MASK;
            w_arvalid_nxt  = 1'b1;
            w_rd_state_nxt = R_AR;
         end
         R_AR: if (m_arready) begin
            w_arvalid_nxt  = 1'b0;
            w_rready_nxt   = 1'b1;
            w_rd_state_nxt = R_DATA;
         end
         R_DATA: if (m_rvalid) begin
            w_rd_data_nxt  = m_rdata;
            w_rd_err_nxt   = (m_rresp != RESP_OKAY);
            w_rready_nxt   = 1'b0;
            w_rd_valid_nxt = 1'b1;
            w_rd_state_nxt = R_HOLD;
         end
         // Full 4-phase: drop on ack high, leave only after ack returns low.
         R_HOLD: begin
            if (r_rd_valid && rd_valid_ack)        w_rd_valid_nxt = 1'b0;
            else if (!r_rd_valid && !rd_valid_ack) w_rd_state_nxt = R_IDLE;
         end
         default: w_rd_state_nxt = R_IDLE;
      endcase
   end

   always_comb begin
      w_wr_state_nxt  = r_wr_state;
      w_awaddr_nxt    = r_awaddr;
      w_wdata_nxt     = r_wdata;
      w_wstrb_nxt     = r_wstrb;
      w_awvalid_nxt   = r_awvalid;
      w_wvalid_nxt    = r_wvalid;
      w_bready_nxt    = r_bready;
      w_wr_done_nxt   = r_wr_done;
      w_wr_err_nxt    = r_wr_err;
      w_wr_rq_ack_nxt = 1'b0;
      case (r_wr_state)
         W_IDLE: if (w_wr_start) begin
            w_awaddr_nxt    = wr_addr;
            w_wdata_nxt     = wr_data;
            w_wstrb_nxt     = '1;
            w_awvalid_nxt   = 1'b1;
            w_wvalid_nxt    = 1'b1;
            w_wr_rq_ack_nxt = 1'b1;
            w_wr_state_nxt  = W_ADDR;
         end
         // AW and W complete independently; a channel already done counts as done.
         W_ADDR: begin
            if (r_awvalid && m_awready) w_awvalid_nxt = 1'b0;
            if (r_wvalid && m_wready)   w_wvalid_nxt  = 1'b0;
            if ((!r_awvalid || m_awready) && (!r_wvalid || m_wready)) begin
               w_bready_nxt   = 1'b1;
               w_wr_state_nxt = W_RESP;
            end
         end
         W_RESP: if (m_bvalid) begin
            w_bready_nxt   = 1'b0;
            w_wr_err_nxt   = (m_bresp != RESP_OKAY);
            w_wr_done_nxt  = 1'b1;
            w_wr_state_nxt = W_DONE;
         end
         W_DONE: begin
            if (r_wr_done && wr_done_ack)        w_wr_done_nxt  = 1'b0;
            else if (!r_wr_done && !wr_done_ack) w_wr_state_nxt = W_IDLE;
         end
         default: w_wr_state_nxt = W_IDLE;
      endcase
   end

   always_ff @(posedge axi_clk) begin
      if (i_rst) begin
         r_rd_state  <= R_IDLE;
         r_araddr    <= '0;
         r_arvalid   <= 1'b0;
         r_rready    <= 1'b0;
         r_rd_data   <= '0;
         r_rd_valid  <= 1'b0;
         r_rd_err    <= 1'b0;
         r_rd_ovf    <= 1'b0;
         r_wr_state  <= W_IDLE;
         r_awaddr    <= '0;
         r_wdata     <= '0;
         r_wstrb     <= '0;
         r_awvalid   <= 1'b0;
         r_wvalid    <= 1'b0;
         r_bready    <= 1'b0;
         r_wr_done   <= 1'b0;
         r_wr_err    <= 1'b0;
         r_wr_rq_ack <= 1'b0;
      end else begin
         r_rd_state  <= w_rd_state_nxt;
         r_araddr    <= w_araddr_nxt;
         r_arvalid   <= w_arvalid_nxt;
         r_rready    <= w_rready_nxt;
         r_rd_data   <= w_rd_data_nxt;
         r_rd_valid  <= w_rd_valid_nxt;
         r_rd_err    <= w_rd_err_nxt;
         r_rd_ovf    <= w_rd_ovf_nxt;
         r_wr_state  <= w_wr_state_nxt;
         r_awaddr    <= w_awaddr_nxt;
         r_wdata     <= w_wdata_nxt;
         r_wstrb     <= w_wstrb_nxt;
         r_awvalid   <= w_awvalid_nxt;
         r_wvalid    <= w_wvalid_nxt;
         r_bready    <= w_bready_nxt;
         r_wr_done   <= w_wr_done_nxt;
         r_wr_err    <= w_wr_err_nxt;
         r_wr_rq_ack <= w_wr_rq_ack_nxt;
      end
   end

   assign rd_data        = r_rd_data;
   assign rd_valid       = r_rd_valid;
   assign rd_err         = r_rd_err;
   assign rd_ovf         = r_rd_ovf;
   assign wr_rq_ack      = r_wr_rq_ack;
   assign wr_done        = r_wr_done;
   assign wr_err         = r_wr_err;
   assign m_araddr       = r_araddr;
   assign m_arprot       = 3'b000;
   assign m_arvalid      = r_arvalid;
   assign m_rready       = r_rready;
   assign m_awaddr       = r_awaddr;
   assign m_awprot       = 3'b000;
   assign m_awvalid      = r_awvalid;
   assign m_wdata        = r_wdata;
   assign m_wstrb        = r_wstrb;
   assign m_wvalid       = r_wvalid;
   assign m_bready       = r_bready;
   assign o_dbg_rd_state = r_rd_state;
   assign o_dbg_wr_state = r_wr_state;

endmodule

// File: tb/tb_cache_axi_lite_master.sv
// Bench for cache_axi_lite_master: a reactive AXI4-Lite slave and cache-side
// monitors check every transfer against scoreboard queues filled when the
// directed steps drive requests.
module tb_cache_axi_lite_master;
  import cache_axi_pkg::*;

  // ---------------- clock / reset ----------------
  logic axi_clk = 1'b0;
  always #5 axi_clk = ~axi_clk;

  logic        i_rst = 1'b1;
  logic        rd_rq = 1'b0;
  logic [31:0] rd_addr = '0;
  logic        wr_rq = 1'b0;
  logic [31:0] wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [31:0] rd_data, m_araddr, m_awaddr, m_wdata;
  logic        rd_valid, rd_err, rd_ovf, wr_rq_ack, wr_done, wr_err;
  logic        rd_valid_ack, wr_done_ack;
  logic [2:0]  m_arprot, m_awprot;
  logic [3:0]  m_wstrb;
  logic        m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready;
  rd_state_e   dbg_rd_state;
  wr_state_e   dbg_wr_state;

  logic        m_arready = 1'b0;
  logic [31:0] m_rdata = '0;
  logic [1:0]  m_rresp = '0;
  logic        m_rvalid = 1'b0;
  logic        m_awready = 1'b0;
  logic        m_wready = 1'b0;
  logic [1:0]  m_bresp = '0;
  logic        m_bvalid = 1'b0;

  // bench control
  logic auto_rd_ack = 1'b0, man_rd_ack = 1'b0;
  logic auto_wr_ack = 1'b1, man_wr_ack = 1'b0;
  logic r_hold = 1'b0;
  int   aw_delay = 0, w_delay = 0, aw_cnt = 0, w_cnt = 0;
  int   ar_seen = 0, rd_seen = 0, wr_done_cnt = 0;
  int   n_vec = 0, n_miss = 0;

  assign rd_valid_ack = auto_rd_ack ? rd_valid : man_rd_ack;
  assign wr_done_ack  = auto_wr_ack ? wr_done  : man_wr_ack;

  // ---------------- scoreboard queues ----------------
  logic [31:0] exp_ar_q[$];   // aligned AR addresses, in order
  logic [33:0] rresp_q[$];    // slave reply {rresp, rdata}
  logic [32:0] exp_rd_q[$];   // expected {rd_err, rd_data}
  logic [31:0] exp_aw_q[$];
  logic [31:0] exp_w_q[$];
  logic [1:0]  bresp_q[$];
  logic [0:0]  exp_wr_q[$];   // expected wr_err

  cache_axi_lite_master #(.ADDR_W(32), .DATA_W(32), .RD_DEPTH(8)) dut (
    .axi_clk(axi_clk), .i_rst(i_rst),
    .rd_rq(rd_rq), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_valid_ack(rd_valid_ack), .rd_err(rd_err), .rd_ovf(rd_ovf),
    .wr_rq(wr_rq), .wr_rq_ack(wr_rq_ack), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_done(wr_done), .wr_done_ack(wr_done_ack), .wr_err(wr_err),
    .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .o_dbg_rd_state(dbg_rd_state), .o_dbg_wr_state(dbg_wr_state)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_avail(input string tag, input int qsize);
    n_vec++;
    assert (qsize != 0) else begin
      n_miss++;
      $error("FAIL %s: observed unexpected transfer expected none", tag);
    end
  endtask

  // ---------------- AXI slave model + AXI-side checks ----------------
  always @(negedge axi_clk) begin
    logic [33:0] rr;
    // AR: accept immediately; ready is a one-cycle pulse, transfer on next edge
    if (m_arvalid && !m_arready) begin
      m_arready = 1'b1;
      chk_avail("ar_extra", exp_ar_q.size());
      if (exp_ar_q.size() != 0) chk("ar_addr", m_araddr, exp_ar_q.pop_front());
      chk("ar_prot", m_arprot, 3'b000);
      ar_seen++;
    end else m_arready = 1'b0;
    // R
    if (m_rready && !m_rvalid && !r_hold && rresp_q.size() != 0) begin
      rr = rresp_q.pop_front();
      m_rvalid = 1'b1;
      m_rresp  = rr[33:32];
      m_rdata  = rr[31:0];
    end else m_rvalid = 1'b0;
    // AW with programmable ready delay
    if (m_awvalid && !m_awready) begin
      if (aw_cnt >= aw_delay) begin
        m_awready = 1'b1;
        aw_cnt = 0;
        chk_avail("aw_extra", exp_aw_q.size());
        if (exp_aw_q.size() != 0) chk("aw_addr", m_awaddr, exp_aw_q.pop_front());
      end else aw_cnt++;
    end else m_awready = 1'b0;
    // W with programmable ready delay
    if (m_wvalid && !m_wready) begin
      if (w_cnt >= w_delay) begin
        m_wready = 1'b1;
        w_cnt = 0;
        chk_avail("w_extra", exp_w_q.size());
        if (exp_w_q.size() != 0) chk("w_data", m_wdata, exp_w_q.pop_front());
        chk("w_strb", m_wstrb, 4'hF);
      end else w_cnt++;
    end else m_wready = 1'b0;
    // B
    if (m_bready && !m_bvalid && bresp_q.size() != 0) begin
      m_bvalid = 1'b1;
      m_bresp  = bresp_q.pop_front();
    end else m_bvalid = 1'b0;
  end

  // ---------------- cache-side monitors ----------------
  logic prev_rd_valid = 1'b0, prev_wr_done = 1'b0;
  always @(negedge axi_clk) begin
    logic [32:0] e;
    if (rd_valid && !prev_rd_valid) begin
      chk_avail("rd_extra", exp_rd_q.size());
      if (exp_rd_q.size() != 0) begin
        e = exp_rd_q.pop_front();
        chk("rd_data", rd_data, e[31:0]);
        chk("rd_err", rd_err, e[32]);
      end
      rd_seen++;
    end
    if (wr_done && !prev_wr_done) begin
      chk_avail("wr_extra", exp_wr_q.size());
      if (exp_wr_q.size() != 0) chk("wr_err", wr_err, exp_wr_q.pop_front());
      wr_done_cnt++;
    end
    prev_rd_valid = rd_valid;
    prev_wr_done  = wr_done;
  end

  // ---------------- driver tasks ----------------
  task automatic push_read(input logic [31:0] a, input logic [31:0] d, input logic [1:0] resp);
    exp_ar_q.push_back(a & 32'hFFFF_FFFC);
    rresp_q.push_back({resp, d});
    exp_rd_q.push_back({(resp != 2'b00), d});
  endtask

  task automatic issue_read(input logic [31:0] a, input logic [31:0] d, input logic [1:0] resp);
    push_read(a, d, resp);
    rd_rq = 1'b1;
    rd_addr = a;
    @(negedge axi_clk);
    rd_rq = 1'b0;
  endtask

  task automatic wait_rd_valid(input string tag);
    for (int i = 0; i < 40 && !rd_valid; i++) @(negedge axi_clk);
    chk(tag, rd_valid, 1'b1);
  endtask

  task automatic ack_read(input string tag);
    man_rd_ack = 1'b1;
    for (int i = 0; i < 10 && rd_valid; i++) @(negedge axi_clk);
    man_rd_ack = 1'b0;
    @(negedge axi_clk);
    chk(tag, rd_valid, 1'b0);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [1:0] resp);
    exp_aw_q.push_back(a);
    exp_w_q.push_back(d);
    bresp_q.push_back(resp);
    exp_wr_q.push_back(resp != 2'b00);
    wr_rq = 1'b1;
    wr_addr = a;
    wr_data = d;
    for (int i = 0; i < 40; i++) begin
      @(negedge axi_clk);
      if (wr_rq_ack) break;
    end
    chk("wr_rq_ack", wr_rq_ack, 1'b1);
    wr_rq = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 400 && (exp_rd_q.size() != 0 || exp_wr_q.size() != 0 || rd_valid || wr_done); i++)
      @(negedge axi_clk);
    chk(tag, exp_rd_q.size() + exp_wr_q.size(), 0);
  endtask

  // ---------------- directed steps ----------------
  initial begin
    int snap;
    repeat (3) @(negedge axi_clk);
    chk("reset_outs", {rd_valid, rd_err, rd_ovf, wr_rq_ack, wr_done, wr_err,
                       m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready}, 0);
    chk("reset_rd_state", dbg_rd_state, R_IDLE);
    i_rst = 1'b0;
    @(negedge axi_clk);

    // 1: single miss, immediate slave; rd_valid four cycles after the pulse
    issue_read(32'h1000_0006, 32'hDEAD_BEEF, 2'b00);
    @(negedge axi_clk);
    @(negedge axi_clk);
    chk("t1_no_early_valid", rd_valid, 1'b0);
    @(negedge axi_clk);
    chk("t1_valid_latency", rd_valid, 1'b1);
    repeat (3) @(negedge axi_clk);
    chk("t1_valid_held", rd_valid, 1'b1);
    chk("t1_data_held", rd_data, 32'hDEAD_BEEF);
    ack_read("t1_ack_drop");

    // 2: read held unacknowledged while 9 misses arrive; 9th overflows
    issue_read(32'h0000_0100, 32'h0000_0A0A, 2'b00);
    wait_rd_valid("t2_first_valid");
    for (int i = 0; i < 9; i++) begin
      if (i == 8) chk("t2_ovf_at_full", rd_ovf, 1'b0);
      if (i < 8) push_read(32'h2000 + i * 4, 32'h5A00_0000 + i, 2'b00);
      rd_rq = 1'b1;
      rd_addr = 32'h2000 + i * 4;
      @(negedge axi_clk);
    end
    rd_rq = 1'b0;
    chk("t2_ovf_set", rd_ovf, 1'b1);
    snap = ar_seen;
    ack_read("t2_first_ack");
    auto_rd_ack = 1'b1;
    drain("t2_drain");
    repeat (10) @(negedge axi_clk);
    chk("t2_ar_count", ar_seen - snap, 8);
    chk("t2_no_9th", m_arvalid, 1'b0);
    auto_rd_ack = 1'b0;

    // 3: AW accepted three cycles before W, then an error response
    aw_delay = 0;
    w_delay = 3;
    snap = wr_done_cnt;
    do_write(32'h0000_0020, 32'h0000_1234, 2'b00);
    @(negedge axi_clk);
    chk("t3_aw_dropped", m_awvalid, 1'b0);
    chk("t3_w_still_high", m_wvalid, 1'b1);
    drain("t3_drain_ok");
    repeat (4) @(negedge axi_clk);
    chk("t3_single_done", wr_done_cnt - snap, 1);
    w_delay = 0;
    do_write(32'h0000_0020, 32'h0000_1234, 2'b10);
    drain("t3_drain_err");

    // 4: read and write requested together; read goes first, write during R_HOLD
    snap = ar_seen;
    push_read(32'h0000_3008, 32'h3333_0001, 2'b00);
    exp_aw_q.push_back(32'h40);
    exp_w_q.push_back(32'h5555);
    bresp_q.push_back(2'b00);
    exp_wr_q.push_back(1'b0);
    rd_rq = 1'b1;
    rd_addr = 32'h3008;
    wr_rq = 1'b1;
    wr_addr = 32'h40;
    wr_data = 32'h5555;
    @(negedge axi_clk);
    rd_rq = 1'b0;
    for (int i = 0; i < 30 && !m_awvalid; i++) @(negedge axi_clk);
    chk("t4_aw_started", m_awvalid, 1'b1);
    chk("t4_read_in_hold", rd_valid, 1'b1);
    chk("t4_read_first", ar_seen - snap, 1);
    chk("t4_wr_ack", wr_rq_ack, 1'b1);
    wr_rq = 1'b0;
    ack_read("t4_rd_ack");
    drain("t4_drain");

    // 5: long ack; rd_valid drops after one cycle, next read waits for ack low
    issue_read(32'h0000_5000, 32'h5555_AAAA, 2'b00);
    wait_rd_valid("t5_valid");
    man_rd_ack = 1'b1;
    push_read(32'h0000_6000, 32'h6666_0000, 2'b01);
    rd_rq = 1'b1;
    rd_addr = 32'h6000;
    @(negedge axi_clk);
    rd_rq = 1'b0;
    chk("t5_drop_after_one", rd_valid, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge axi_clk);
      chk("t5_no_ar_while_ack", m_arvalid, 1'b0);
    end
    man_rd_ack = 1'b0;
    wait_rd_valid("t5_next_valid");
    ack_read("t5_next_ack");
    drain("t5_drain");

    // 6: reset while waiting for R data with more misses queued
    r_hold = 1'b1;
    @(negedge axi_clk);
    issue_read(32'h0000_7000, 32'h7777_7777, 2'b00);
    for (int i = 0; i < 20 && !m_rready; i++) @(negedge axi_clk);
    chk("t6_in_r_data", dbg_rd_state, R_DATA);
    rd_rq = 1'b1;
    rd_addr = 32'h7100;
    @(negedge axi_clk);
    rd_addr = 32'h7104;
    @(negedge axi_clk);
    rd_rq = 1'b0;
    chk("t6_ovf_before", rd_ovf, 1'b1);
    i_rst = 1'b1;
    @(negedge axi_clk);
    chk("t6_outs_zero", {rd_valid, rd_err, rd_ovf, wr_rq_ack, wr_done, wr_err,
                         m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready}, 0);
    chk("t6_rd_data_zero", rd_data, 0);
    chk("t6_araddr_zero", m_araddr, 0);
    chk("t6_rd_state", dbg_rd_state, R_IDLE);
    i_rst = 1'b0;
    exp_rd_q.delete();
    rresp_q.delete();
    r_hold = 1'b0;
    snap = ar_seen;
    repeat (8) @(negedge axi_clk);
    chk("t6_fifo_flushed", ar_seen - snap, 0);
    chk("t6_no_arvalid", m_arvalid, 1'b0);

    // recovery after reset, error response on a read
    auto_rd_ack = 1'b1;
    issue_read(32'h0000_8003, 32'hCAFE_0001, 2'b10);
    drain("t7_drain");
    chk("t7_ar_count", ar_seen - snap, 1);
    chk("final_queues", exp_ar_q.size() + exp_aw_q.size() + exp_w_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no completion expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
